// File: rtl/iram_pkg.sv
`default_nettype none
// ============================================================================
// iram_pkg : shared types and helpers for the streamable instruction memory
// Rev 1.0  : initial release
// ============================================================================
package iram_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_LOAD  = 2'd2
  } iram_state_e;

  localparam int unsigned c_NOP_DEFAULT = 0;

  function automatic int iram_bytes(input int data_w);
    return data_w / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/iram_byte_packer.sv
`default_nettype none
// ============================================================================
// iram_byte_packer : big-endian byte-to-word assembler with pad-on-last
// Rev 1.0          : initial release
// ============================================================================
module iram_byte_packer
  import iram_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_accept,
  input  logic [7:0]        i_data,
  input  logic              i_last,
  output logic              o_word_valid,
  output logic [DATA_W-1:0] o_word
);

  localparam int               c_BYTES    = iram_bytes(DATA_W);
  localparam int               c_CNT_W    = (c_BYTES > 1) ? $clog2(c_BYTES) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(c_BYTES - 1);

  logic [c_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [DATA_W-1:0]  asm_q, asm_d;
  logic [DATA_W-1:0]  w_shifted;
  logic               w_done;

  always_comb begin
    w_shifted    = (asm_q << 8) | DATA_W'(i_data);
    w_done       = i_accept && ((byte_cnt_q == c_LAST_CNT) || i_last);
    o_word_valid = w_done;
    // A short final word moves its bytes to the top, leaving zero padding below.
    o_word       = w_shifted << (8 * (c_BYTES - 1 - int'(byte_cnt_q)));
    byte_cnt_d   = byte_cnt_q;
    asm_d        = asm_q;
    if (i_clear || w_done) begin
      byte_cnt_d = '0;
      asm_d      = '0;
    end else if (i_accept) begin
      byte_cnt_d = byte_cnt_q + c_CNT_W'(1);
      asm_d      = w_shifted;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_cnt_q <= '0;
      asm_q      <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/iram_stream_loader.sv
`default_nettype none
// ============================================================================
// iram_stream_loader : instruction memory with combinational fetch, clear
//                      sweep and runtime byte-stream load port
// Rev 1.0            : initial release
// ============================================================================
module iram_stream_loader
  import iram_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 8,
  parameter int                DEPTH    = 128,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(c_NOP_DEFAULT)
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] Q,
  output logic              STALL,
  output logic              MISALIGN,
  input  logic              LD_START,
  input  logic [ADDR_W-1:0] LD_BASE,
  input  logic              LD_VALID,
  input  logic [7:0]        LD_DATA,
  input  logic              LD_LAST,
  output logic              LD_READY,
  output logic              LD_ERR
);

  localparam int                 c_IDX_W  = ADDR_W - 1;
  localparam int                 c_PTR_W  = ADDR_W;
  localparam int                 c_MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_PTR_W-1:0] c_DEPTH  = c_PTR_W'(DEPTH);
  localparam logic [c_PTR_W-1:0] c_LAST   = c_PTR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  iram_state_e        state_q, state_d;
  logic [c_PTR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [c_PTR_W-1:0] ld_ptr_q, ld_ptr_d;
  logic               ld_err_q, ld_err_d;

  logic                w_mem_we;
  logic [c_MEM_AW-1:0] w_mem_waddr;
  logic [DATA_W-1:0]   w_mem_wdata;
  logic                w_stall;
  logic                w_ready;
  logic                w_pk_clear;
  logic                w_pk_accept;
  logic                w_pk_valid;
  logic [DATA_W-1:0]   w_pk_word;
  logic [c_IDX_W-1:0]  w_idx;
  logic                w_in_range;
  logic [DATA_W-1:0]   w_fetch;
  logic                w_unused_base_lsb;

  assign w_unused_base_lsb = LD_BASE[0];

  iram_byte_packer #(
    .DATA_W (DATA_W)
  ) u_packer (
    .clk          (CLK),
    .rst_n        (RESET_N),
    .i_clear      (w_pk_clear),
    .i_accept     (w_pk_accept),
    .i_data       (LD_DATA),
    .i_last       (LD_LAST),
    .o_word_valid (w_pk_valid),
    .o_word       (w_pk_word)
  );

  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    ld_ptr_d    = ld_ptr_q;
    ld_err_d    = ld_err_q;
    w_mem_we    = 1'b0;
    w_mem_waddr = '0;
    w_mem_wdata = NOP_WORD;
    w_stall     = 1'b1;
    w_ready     = 1'b0;
    w_pk_clear  = 1'b0;
    w_pk_accept = 1'b0;

    unique case (state_q)
      ST_CLEAR: begin
        w_mem_we    = 1'b1;
        w_mem_waddr = clr_ptr_q[c_MEM_AW-1:0];
        clr_ptr_d   = clr_ptr_q + c_PTR_W'(1);
        if (clr_ptr_q == c_LAST) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        w_stall = 1'b0;
        if (LD_START) begin
          state_d    = ST_LOAD;
          ld_ptr_d   = {1'b0, LD_BASE[ADDR_W-1:1]};
          ld_err_d   = 1'b0;
          w_pk_clear = 1'b1;
        end
      end
      ST_LOAD: begin
        w_ready     = 1'b1;
        w_pk_accept = LD_VALID;
        if (w_pk_valid) begin
          // Pointer saturates at DEPTH so any further words only raise LD_ERR.
          if (ld_ptr_q < c_DEPTH) begin
            w_mem_we    = 1'b1;
            w_mem_waddr = ld_ptr_q[c_MEM_AW-1:0];
            w_mem_wdata = w_pk_word;
            ld_ptr_d    = ld_ptr_q + c_PTR_W'(1);
          end else begin
            ld_err_d = 1'b1;
          end
        end
        if (LD_VALID && LD_LAST) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_ptr_d = '0;
      end
    endcase

    // Reset must neither write memory nor expose a fetchable word.
    if (!RESET_N) begin
      w_mem_we = 1'b0;
      w_stall  = 1'b1;
      w_ready  = 1'b0;
    end
  end

  always_comb begin
    w_idx      = ADDR[ADDR_W-1:1];
    w_in_range = ({1'b0, w_idx} < c_DEPTH);
    w_fetch    = w_in_range ? mem[w_idx[c_MEM_AW-1:0]] : NOP_WORD;
  end

  assign Q        = w_stall ? NOP_WORD : w_fetch;
  assign STALL    = w_stall;
  assign MISALIGN = ADDR[0] && !w_stall;
  assign LD_READY = w_ready;
  assign LD_ERR   = ld_err_q;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
      ld_ptr_q  <= '0;
      ld_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      ld_ptr_q  <= ld_ptr_d;
      ld_err_q  <= ld_err_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_mem_we) begin
      mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iram_stream_loader.sv
`default_nettype none
// ============================================================================
// tb_iram_stream_loader : randomized self-checking bench with memory model
// Rev 1.0               : initial release
// ============================================================================
module tb_iram_stream_loader;

  localparam int c_DATA_W = 16;
  localparam int c_ADDR_W = 8;
  localparam int c_DEPTH  = 128;

  logic                CLK = 1'b0;
  logic                RESET_N = 1'b0;
  logic [c_ADDR_W-1:0] ADDR = '0;
  logic [c_DATA_W-1:0] Q;
  logic                STALL;
  logic                MISALIGN;
  logic                LD_START = 1'b0;
  logic [c_ADDR_W-1:0] LD_BASE = '0;
  logic                LD_VALID = 1'b0;
  logic [7:0]          LD_DATA = '0;
  logic                LD_LAST = 1'b0;
  logic                LD_READY;
  logic                LD_ERR;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] model_mem [c_DEPTH];
  logic        model_err = 1'b0;
  logic [7:0]  stim_q [$];

  iram_stream_loader #(
    .DATA_W   (c_DATA_W),
    .ADDR_W   (c_ADDR_W),
    .DEPTH    (c_DEPTH),
    .NOP_WORD (16'h0000)
  ) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .ADDR     (ADDR),
    .Q        (Q),
    .STALL    (STALL),
    .MISALIGN (MISALIGN),
    .LD_START (LD_START),
    .LD_BASE  (LD_BASE),
    .LD_VALID (LD_VALID),
    .LD_DATA  (LD_DATA),
    .LD_LAST  (LD_LAST),
    .LD_READY (LD_READY),
    .LD_ERR   (LD_ERR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Hold reset for n edges, then count cycles until the clear sweep finishes.
  task automatic do_reset(input int n);
    int cnt;
    RESET_N  = 1'b0;
    LD_START = 1'b0;
    LD_VALID = 1'b0;
    LD_LAST  = 1'b0;
    ADDR     = 8'h03;
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
    @(negedge CLK);
    check_eq("rst_stall", STALL, 1);
    check_eq("rst_ready", LD_READY, 0);
    check_eq("rst_q", Q, 16'h0000);
    check_eq("rst_misalign", MISALIGN, 0);
    check_eq("rst_err", LD_ERR, 0);
    RESET_N = 1'b1;
    cnt = 0;
    while (STALL && cnt < 1000) begin
      @(posedge CLK);
      #1;
      cnt++;
    end
    check_eq("clear_len", cnt, c_DEPTH);
    for (int i = 0; i < c_DEPTH; i++) model_mem[i] = 16'h0000;
    model_err = 1'b0;
  endtask

  task automatic check_mem(input string tag);
    LD_START = 1'b0;
    for (int a = 0; a < 256; a += 2) begin
      ADDR = 8'(a);
      #1;
      check_eq(tag, Q, model_mem[a >> 1]);
    end
    check_eq("idle_misalign_even", MISALIGN, 0);
  endtask

  // gap_mode: 0 back-to-back, 1 two idle cycles per byte, 2 random gaps
  // with stray LD_START pulses that the loader must ignore.
  task automatic do_load(input logic [7:0] base, input int gap_mode);
    int          n;
    int          ptr;
    int          gaps;
    logic [15:0] w;
    n   = stim_q.size();
    ptr = base >> 1;
    model_err = 1'b0;
    for (int i = 0; i < n; i += 2) begin
      w = {stim_q[i], (i + 1 < n) ? stim_q[i+1] : 8'h00};
      if (ptr < c_DEPTH) begin
        model_mem[ptr] = w;
        ptr++;
      end else begin
        model_err = 1'b1;
      end
    end

    @(negedge CLK);
    LD_START = 1'b1;
    LD_BASE  = base;
    @(posedge CLK);
    #1;
    LD_START = 1'b0;
    for (int i = 0; i < n; i++) begin
      LD_START = 1'b0;
      LD_VALID = 1'b1;
      LD_DATA  = stim_q[i];
      LD_LAST  = (i == n - 1);
      @(negedge CLK);
      if (i == 0) check_eq("start_clears_err", LD_ERR, 0);
      check_eq("load_ready", LD_READY, 1);
      check_eq("load_stall", STALL, 1);
      @(posedge CLK);
      #1;
      LD_VALID = 1'b0;
      LD_LAST  = 1'b0;
      gaps = (gap_mode == 1) ? 2 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      if (i < n - 1) begin
        repeat (gaps) begin
          if (gap_mode == 2) begin
            LD_START = 1'($urandom_range(0, 1));
            LD_BASE  = 8'($urandom);
          end
          LD_DATA = 8'($urandom);
          @(negedge CLK);
          check_eq("gap_ready", LD_READY, 1);
          check_eq("gap_q_nop", Q, 16'h0000);
          @(posedge CLK);
          #1;
          LD_START = 1'b0;
        end
      end
    end
    @(negedge CLK);
    check_eq("end_stall", STALL, 0);
    check_eq("end_ready", LD_READY, 0);
    check_eq("end_err", LD_ERR, model_err);
  endtask

  initial begin
    logic [7:0] a;
    logic [7:0] base;
    int         len;

    do_reset(2);
    check_mem("clear_contents");

    stim_q = '{8'hF0, 8'h01, 8'hF2, 8'h91};
    do_load(8'h10, 0);
    ADDR = 8'h12;
    #1;
    check_eq("basic_q12", Q, 16'hF291);
    ADDR = 8'h10;
    #1;
    check_eq("basic_q10", Q, 16'hF001);

    stim_q = '{8'hF0, 8'h01, 8'hF2, 8'h91};
    do_load(8'h20, 1);
    ADDR = 8'h22;
    #1;
    check_eq("gap_q22", Q, 16'hF291);
    check_mem("gap_contents");

    stim_q = '{8'hAB};
    do_load(8'h00, 0);
    ADDR = 8'h00;
    #1;
    check_eq("partial_q0", Q, 16'hAB00);
    check_eq("partial_err", LD_ERR, 0);

    stim_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    do_load(8'hFC, 0);
    check_eq("ovf_err", LD_ERR, 1);
    ADDR = 8'hFC;
    #1;
    check_eq("ovf_q126", Q, 16'h1122);
    ADDR = 8'hFE;
    #1;
    check_eq("ovf_q127", Q, 16'h3344);
    check_mem("ovf_contents");

    for (int t = 0; t < 24; t++) begin
      base = 8'($urandom);
      len  = int'($urandom_range(1, 9));
      stim_q.delete();
      for (int k = 0; k < len; k++) stim_q.push_back(8'($urandom));
      do_load(base, int'($urandom_range(0, 2)));
      for (int k = 0; k < 8; k++) begin
        a = (k == 0) ? base : 8'($urandom);
        ADDR = a;
        #1;
        check_eq("rand_q", Q, model_mem[a >> 1]);
        check_eq("rand_misalign", MISALIGN, a[0]);
      end
    end
    check_mem("rand_contents");

    @(negedge CLK);
    LD_START = 1'b1;
    LD_BASE  = 8'h40;
    @(posedge CLK);
    #1;
    LD_START = 1'b0;
    for (int k = 0; k < 3; k++) begin
      LD_VALID = 1'b1;
      LD_DATA  = 8'hC0 + 8'(k);
      @(posedge CLK);
      #1;
    end
    LD_VALID = 1'b0;
    do_reset(1);
    check_mem("midload_reset_contents");

    stim_q = '{8'h5A, 8'hA5};
    do_load(8'h04, 0);
    ADDR = 8'h05;
    #1;
    check_eq("misalign_flag", MISALIGN, 1);
    check_eq("misalign_q", Q, 16'h5AA5);
    ADDR = 8'h04;
    #1;
    check_eq("aligned_flag", MISALIGN, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
